feedback_loop_inverse: RTL
==========================

# feedback_loop_inverse

- Streaming first-difference decoder: y[n] = x[n] − x[n−1], with history starting at 0.
- Exact inverse of the feedback-loop accumulator: fed an accumulator's wrapped output, it recovers the original input sequence.
- Sits downstream of the accumulator in the loopback test path, and at the receive end of accumulated-sample links.
- Valid/ready on both sides, one-cycle latency, full throughput.

## Interface
Parameters:
- WIDTH, 8, sample width in bits (signed two's complement)

Ports:
- system1000  in  1  clock
- system1000_rstn  in  1  asynchronous reset, active low
- in_data  in  WIDTH  signed input sample
- in_valid  in  1  input sample present
- in_ready  out  1  block can accept a sample
- restart  in  1  synchronous; clears difference history to 0
- out_data  out  WIDTH  signed difference
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- ovf  out  1  sticky: a difference fell outside WIDTH-bit signed range

## Operation
- Input accept: in_valid && in_ready.
- Output transfer: out_valid && out_ready.
- History register `prev` (WIDTH bits):
  - reset value 0;
  - loaded with in_data on every accept.
- Difference is computed at WIDTH+1 bits: d = in_data − prev_eff.
  - prev_eff = 0 if restart is high in the accept cycle, else prev.
- restart:
  - without an accept: prev ← 0.
  - with an accept: the accepted sample uses 0 as history, and prev ← in_data.
  - Does not flush already-computed outputs.
- Overflow: d outside [−2^(WIDTH−1), 2^(WIDTH−1)−1] sets ovf.
  - ovf is cleared only by reset or restart.
  - If restart and an overflowing accept occur in the same cycle, ovf ends set.
- Output buffering is a 2-entry skid stage with states EMPTY, ONE, FULL:
  - EMPTY→ONE on accept.
  - ONE→FULL on accept without transfer.
  - ONE→EMPTY on transfer without accept.
  - FULL→ONE on transfer. No accept is possible in FULL.
  - Simultaneous accept and transfer in ONE stays in ONE.
- Order is always preserved; no sample is dropped or duplicated.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, ovf=0, prev=0.
- Reset is asynchronous and may assert mid-stream: buffered samples are discarded and all outputs return to reset values immediately.
- Latency: sample accepted at edge k appears on out_data/out_valid after edge k (valid in cycle k+1).
- Throughput: 1 sample/cycle while out_ready=1.
- in_ready is registered: in_ready=0 exactly when the skid stage is FULL. There is no combinational path from out_ready to in_ready.
- out_data is held stable while out_valid && !out_ready.

## Configuration
- Macro FEEDBACK_LOOP_INVERSE_SAT_EN.
- Undefined (default): out_data = d[WIDTH−1:0], i.e. modular wrap. This is the exact inverse of the wrapping accumulator. ovf still flags wrap events.
- Defined: out_data is saturated to −2^(WIDTH−1) or 2^(WIDTH−1)−1 on overflow. ovf behaviour is unchanged.

## Structure
- Package feedback_loop_pkg holds:
  - default WIDTH constant;
  - functions for signed min/max limits per width;
  - skid state enum (EMPTY, ONE, FULL).
- Sub-module feedback_loop_skid:
  - generic 2-entry valid/ready skid buffer, WIDTH-parameterised;
  - owns in_ready and out_valid/out_data.
- Top level holds prev, the subtractor, wrap/saturation logic and ovf.

## Test plan
All scenarios use WIDTH=8.
- Reset: assert rstn=0 mid-stream → out_valid=0, in_ready=1, ovf=0 the same cycle; first sample after release, 9, yields 9.
- Basic stream, out_ready=1: inputs 10, 15, 12, 12 → outputs 10, 5, −3, 0, each one cycle after accept, back-to-back.
- Overflow, inputs 100, −100:
  - default build: outputs 100, 56, ovf=1;
  - with FEEDBACK_LOOP_INVERSE_SAT_EN: outputs 100, −128, ovf=1.
- Backpressure: out_ready=0 for 4 cycles while offering 1, 2, 3, 4 every cycle.
  - in_ready drops after 2 accepts; no output transfers while out_ready=0.
  - On release, outputs 1, 1, 1, 1 in order, with no loss or duplication.
- Restart with concurrent accept: history 50, then restart=1 with in_data=7 accepted → output 7, ovf cleared.
  - Next input 10 → output 3.
- Round trip: random signed 8-bit stream through the accumulator then this block (default build) → output equals the original stream for 10,000 samples, with random out_ready stalls.

Source files
------------

// File: rtl/feedback_loop_pkg.sv
// feedback_loop_pkg: shared width default, signed limits and
// skid-buffer state encoding for the first-difference decoder.
package feedback_loop_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } skid_state_t;

    function automatic logic signed [31:0] smax(input int w);
        return (32'sd1 <<< (w - 1)) - 32'sd1;
    endfunction

    function automatic logic signed [31:0] smin(input int w);
        return -(32'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/feedback_loop_inverse_if.sv
// feedback_loop_inverse_if: sample stream in, difference stream out,
// plus restart control and sticky overflow flag.
interface feedback_loop_inverse_if
    import feedback_loop_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             restart;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             ovf;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        output restart,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  ovf
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        input  restart,
        output out_data,
        output out_valid,
        input  out_ready,
        output ovf
    );

endinterface

// File: rtl/feedback_loop_skid.sv
// feedback_loop_skid: 2-entry valid/ready skid buffer with registered
// ready, so the upstream never sees a combinational path from m_ready.
module feedback_loop_skid
    import feedback_loop_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);

    skid_state_t      state;
    logic [WIDTH-1:0] tail;
    logic             push;
    logic             pop;

    assign push = s_valid && s_ready;
    assign pop  = m_valid && m_ready;

    // m_data is the head entry; tail only holds data while FULL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            s_ready <= 1'b1;
            m_valid <= 1'b0;
            m_data  <= '0;
            tail    <= '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (push) begin
                        m_data  <= s_data;
                        m_valid <= 1'b1;
                        state   <= ONE;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        tail    <= s_data;
                        s_ready <= 1'b0;
                        state   <= FULL;
                    end else if (push) begin
                        m_data <= s_data;
                    end else if (pop) begin
                        m_valid <= 1'b0;
                        state   <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        m_data  <= tail;
                        s_ready <= 1'b1;
                        state   <= ONE;
                    end
                end
                default: begin
                    s_ready <= 1'b1;
                    m_valid <= 1'b0;
                    state   <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/feedback_loop_inverse.sv
// feedback_loop_inverse: streaming first-difference decoder y = x - x_prev.
// Define FEEDBACK_LOOP_INVERSE_SAT_EN to saturate instead of wrap.
module feedback_loop_inverse
    import feedback_loop_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic                   system1000,
    input logic                   system1000_rstn,
    feedback_loop_inverse_if.slave bus
);

    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] prev_eff;
    logic [WIDTH-1:0] res;
    logic [WIDTH:0]   diff;
    logic             accept;
    logic             wrap;
    logic             ovf;

    assign accept   = bus.in_valid && bus.in_ready;
    assign prev_eff = bus.restart ? '0 : prev;
    assign diff     = {bus.in_data[WIDTH-1], bus.in_data}
                    - {prev_eff[WIDTH-1], prev_eff};
    // Sign bits disagree when the true difference leaves WIDTH bits.
    assign wrap     = diff[WIDTH] ^ diff[WIDTH-1];

`ifdef FEEDBACK_LOOP_INVERSE_SAT_EN
    localparam logic signed [31:0] MAX_W = smax(WIDTH);
    localparam logic signed [31:0] MIN_W = smin(WIDTH);

    assign res = !wrap      ? diff[WIDTH-1:0]
               : diff[WIDTH] ? MIN_W[WIDTH-1:0]
               :               MAX_W[WIDTH-1:0];
`else
    assign res = diff[WIDTH-1:0];
`endif

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            prev <= '0;
            ovf  <= 1'b0;
        end else begin
            if (accept) begin
                prev <= bus.in_data;
            end else if (bus.restart) begin
                prev <= '0;
            end
            if (bus.restart) begin
                ovf <= accept && wrap;
            end else if (accept && wrap) begin
                ovf <= 1'b1;
            end
        end
    end

    assign bus.ovf = ovf;

    feedback_loop_skid #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk    (system1000),
        .rst_n  (system1000_rstn),
        .s_data (res),
        .s_valid(bus.in_valid),
        .s_ready(bus.in_ready),
        .m_data (bus.out_data),
        .m_valid(bus.out_valid),
        .m_ready(bus.out_ready)
    );

endmodule
